key_cmd_ctrl: RTL and testbench

// Sits directly downstream of the PS/2 keyboard decoder. Turns its level key

---
 rtl/trex_pkg.sv | 14 +
 rtl/key_cmd_ctrl_rise_det.sv | 21 ++
 rtl/key_cmd_ctrl.sv | 123 ++++++++++++
 tb/tb_key_cmd_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trex_pkg.sv
// Shared types and constants for the T-rex game control path.
// Jump FSM state encoding and default jump hold threshold.
package trex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ISSUE,
    WAIT_REL
  } jmp_state_t;

  localparam int HOLD_TICKS_DEF = 150;

endpackage

// File: rtl/key_cmd_ctrl_rise_det.sv
// 1-bit registered rising-edge detector, reset value selectable.
// Ports: clk, rst (sync, active-low), d (level), rise (d high, prev low).
module rise_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (!rst) q <= RST_VAL;
    else      q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/key_cmd_ctrl.sv
// Key levels to game commands: start pulse, short/long jump, duck.
// Ports: clk, rst, ms_tick, up/space/down/enter, start_pulse,
//        jump_valid/jump_long/jump_ready handshake, duck.
module key_cmd_ctrl
  import trex_pkg::*;
#(
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic up,
  input  logic space,
  input  logic down,
  input  logic enter,
  output logic start_pulse,
  output logic jump_valid,
  output logic jump_long,
  input  logic jump_ready,
  output logic duck
);

  if (HOLD_TICKS < 1 ||
      HOLD_TICKS > (1 << CNT_W) - 1) begin : g_chk
    $error("HOLD_TICKS does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(HOLD_TICKS - 1);

  logic             jkey;
  logic             rise_j;
  logic             rise_e;
  jmp_state_t       state;
  jmp_state_t       state_d;
  logic             long_q;
  logic             long_d;
  logic [CNT_W-1:0] cnt;

  assign jkey = up | space;

  // Reset to 1: a key held through reset must be released first.
  rise_det #(.RST_VAL(1'b1)) u_rise_j (
    .clk  (clk),
    .rst  (rst),
    .d    (jkey),
    .rise (rise_j)
  );

  rise_det #(.RST_VAL(1'b1)) u_rise_e (
    .clk  (clk),
    .rst  (rst),
    .d    (enter),
    .rise (rise_e)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      long_q <= 1'b0;
    end else begin
      state  <= state_d;
      long_q <= long_d;
    end
  end

  // Enter edge aborts whatever the jump FSM is doing.
  always_comb begin
    state_d = state;
    long_d  = long_q;
    if (rise_e) begin
      state_d = jkey ? WAIT_REL : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise_j) state_d = HOLD;
        end
        HOLD: begin
          if (!jkey) begin
            state_d = ISSUE;
            long_d  = 1'b0;
          end else if (ms_tick && cnt == CNT_MAX) begin
            state_d = ISSUE;
            long_d  = 1'b1;
          end
        end
        ISSUE: begin
          if (jump_ready) state_d = jkey ? WAIT_REL : IDLE;
        end
        WAIT_REL: begin
          if (!jkey) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == IDLE && rise_j) begin
      cnt <= '0;
    end else if (state == HOLD && ms_tick &&
                 cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      start_pulse <= 1'b0;
      duck        <= 1'b0;
    end else begin
      start_pulse <= rise_e;
      duck        <= down && state == IDLE && !jkey;
    end
  end

  assign jump_valid = (state == ISSUE);
  assign jump_long  = long_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Self-checking bench for key_cmd_ctrl: directed key sequences,
// per-cycle comparison against a behavioural model.
module tb_key_cmd_ctrl;

  localparam int HT = 150;

  logic clk = 1'b0;
  logic rst, ms_tick, up, space, down, enter, jump_ready;
  logic start_pulse, jump_valid, jump_long, duck;

  int n_vec = 0;
  int n_err = 0;

  key_cmd_ctrl #(.HOLD_TICKS(HT), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ms_tick     (ms_tick),
    .up          (up),
    .space       (space),
    .down        (down),
    .enter       (enter),
    .start_pulse (start_pulse),
    .jump_valid  (jump_valid),
    .jump_long   (jump_long),
    .jump_ready  (jump_ready),
    .duck        (duck)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // 1 ms strobe: one clk high every 4 clks.
  initial begin
    int tc;
    tc = 0;
    ms_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tc = (tc + 1) % 4;
      ms_tick = (tc == 0);
    end
  end

  // Behavioural model: a jump is "being timed", "pending", or
  // "waiting for release"; nothing set means idle.
  bit m_timing, m_pending, m_waitrel, m_long;
  bit m_start, m_duck, m_rst, prev_j, prev_e;
  int m_ticks;
  bit chk_en = 0;

  always @(posedge clk) begin
    bit j, rj, re, idle_now;
    if (!rst) begin
      m_timing = 0; m_pending = 0; m_waitrel = 0;
      m_long = 0; m_start = 0; m_duck = 0;
      prev_j = 1; prev_e = 1; m_ticks = 0;
      m_rst = 1;
    end else begin
      m_rst = 0;
      j  = up | space;
      rj = j && !prev_j;
      re = enter && !prev_e;
      idle_now = !m_timing && !m_pending && !m_waitrel;
      m_duck  = down && idle_now && !j;
      m_start = re;
      if (re) begin
        m_timing = 0; m_pending = 0; m_waitrel = j;
      end else if (m_timing) begin
        if (!j) begin
          m_timing = 0; m_pending = 1; m_long = 0;
        end else if (ms_tick) begin
          m_ticks++;
          if (m_ticks == HT) begin
            m_timing = 0; m_pending = 1; m_long = 1;
          end
        end
      end else if (m_pending) begin
        if (jump_ready) begin
          m_pending = 0; m_waitrel = j;
        end
      end else if (m_waitrel) begin
        if (!j) m_waitrel = 0;
      end else if (rj) begin
        m_timing = 1; m_ticks = 0;
      end
      prev_j = j;
      prev_e = enter;
    end
  end

  int n_vcyc = 0;
  int n_hs   = 0;
  int last_long = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("start_pulse", start_pulse, m_start);
      check("jump_valid", jump_valid, m_pending);
      check("duck", duck, m_duck);
      if (m_pending || m_rst)
        check("jump_long", jump_long, m_long);
      if (jump_valid) begin
        n_vcyc++;
        last_long = jump_long;
        if (jump_ready) n_hs++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until n strobes have been sampled by the DUT.
  task automatic run_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ms_tick) k++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, h0;
    rst = 0; up = 0; space = 1; down = 0;
    enter = 0; jump_ready = 0;
    step(1);
    chk_en = 1;
    step(2);
    @(negedge clk);
    check("rst_valid", jump_valid, 0);
    check("rst_start", start_pulse, 0);
    check("rst_long", jump_long, 0);
    check("rst_duck", duck, 0);

    // Space held across reset release: no jump.
    rst = 1;
    step(40);
    check("held_thru_rst", n_vcyc, 0);
    space = 0;
    step(2);
    space = 1;
    step(3);
    // Reset asserted while in HOLD.
    down = 1;
    rst = 0;
    step(1);
    @(negedge clk);
    check("rst_hold_valid", jump_valid, 0);
    check("rst_hold_duck", duck, 0);
    rst = 1; space = 0; down = 0;
    step(4);

    // Short tap, ready high.
    jump_ready = 1;
    v0 = n_vcyc; h0 = n_hs;
    space = 1;
    step(1);
    run_ticks(20);
    space = 0;
    step(6);
    check("tap_vcyc", n_vcyc - v0, 1);
    check("tap_long", last_long, 0);
    check("tap_hs", n_hs - h0, 1);

    // Long hold, accepted late at tick 180.
    jump_ready = 0;
    h0 = n_hs;
    up = 1;
    step(1);
    run_ticks(HT - 1);
    @(negedge clk);
    check("long_t149_valid", jump_valid, 0);
    run_ticks(1);
    @(negedge clk);
    check("long_t150_valid", jump_valid, 1);
    check("long_t150_long", jump_long, 1);
    run_ticks(30);
    @(negedge clk);
    check("long_t180_valid", jump_valid, 1);
    jump_ready = 1;
    @(posedge clk);
    #1;
    jump_ready = 0;
    @(negedge clk);
    check("long_hs_drop", jump_valid, 0);
    check("long_hs", n_hs - h0, 1);
    run_ticks(20);
    up = 0;
    step(5);
    check("long_idle", jump_valid, 0);

    // Enter edge while ISSUE: abort, no handshake.
    h0 = n_hs;
    space = 1;
    step(5);
    space = 0;
    step(1);
    @(negedge clk);
    check("abort_pre_valid", jump_valid, 1);
    enter = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_start", start_pulse, 1);
    check("abort_valid", jump_valid, 0);
    @(negedge clk);
    check("abort_start_1cyc", start_pulse, 0);
    enter = 0;
    check("abort_hs", n_hs - h0, 0);
    step(3);

    // Duck, overridden by a jump, restored after.
    down = 1;
    step(3);
    @(negedge clk);
    check("duck_on", duck, 1);
    space = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("duck_drop", duck, 0);
    step(4);
    jump_ready = 1;
    space = 0;
    step(3);
    @(negedge clk);
    check("duck_back", duck, 1);
    down = 0; jump_ready = 0;
    step(3);

    // Enter edge during HOLD with key held: no jump issued.
    v0 = n_vcyc;
    space = 1;
    step(3);
    enter = 1;
    step(1);
    enter = 0;
    step(3);
    space = 0;
    step(4);
    check("abort_hold_vcyc", n_vcyc - v0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
